// File: rtl/axi_burst_master_pkg.sv
// Shared encodings, FSM state type and burst-legality helpers for the AXI4 burst master.
// Burst/response codes follow the AXI4 encodings used by the simulated RAM slave.
package axi_burst_master_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  // True when a burst starting at page offset addr_lo with len+1 beats runs past the 4KB page.
  // 20 bits covers the worst case of 4095 + 256 beats * 128 bytes.
  function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                      input logic [7:0]  len,
                                      input logic [7:0]  bytes_per_beat);
    logic [19:0] end_off;
    end_off = {8'd0, addr_lo} + ({12'd0, len} + 20'd1) * {12'd0, bytes_per_beat};
    return end_off > 20'd4096;
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 five-channel bus bundle between the burst master and an AXI4 slave.
interface axi_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_burst_master_beat_counter.sv
// Remaining-beat counter for one burst: loaded with len (beats minus 1), counts down to 0.
module axi_burst_master_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] count,
  output logic       last
);

  // Holding at zero keeps a stray decrement from wrapping to 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign last = (count == 8'd0);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 initiator: turns one command plus a write/read beat stream
// into an INCR burst and reports a completion record with the accumulated response.
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,

  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,

  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,

  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  done_write,
  output logic [1:0]            done_resp,

  axi_burst_master_if.master    m_axi
);

  localparam logic [2:0] AXI_SIZE   = 3'($clog2(STRB_WIDTH));
  localparam logic [7:0] BEAT_BYTES = 8'(STRB_WIDTH);

  state_t                state;
  state_t                state_nx;

  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            resp_acc;

  logic                  cmd_hs;
  logic                  cmd_cross;
  logic                  w_beat;
  logic                  r_beat;
  logic                  r_err;
  logic [7:0]            beat_cnt;
  logic                  beat_last;

  // The write response ID carries no information for a single-outstanding master.
  logic                  unused_bid;
  assign unused_bid = ^m_axi.bid;

  assign cmd_hs    = cmd_valid && (state == ST_IDLE);
  assign cmd_cross = crosses_4k(cmd_addr[11:0], cmd_len, BEAT_BYTES);
  assign w_beat    = (state == ST_W) && wr_valid && m_axi.wready;
  assign r_beat    = (state == ST_R) && m_axi.rvalid && rd_ready;
  assign r_err     = (m_axi.rid != id_q) || (m_axi.rlast != beat_last);

  axi_burst_master_beat_counter u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_hs),
    .load_val (cmd_len),
    .dec      (w_beat || r_beat),
    .count    (beat_cnt),
    .last     (beat_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_cross) begin
            state_nx = ST_DONE;
          end else if (cmd_write) begin
            state_nx = ST_AW;
          end else begin
            state_nx = ST_AR;
          end
        end
      end
      ST_AW:   if (m_axi.awready) state_nx = ST_W;
      ST_W:    if (w_beat && beat_last) state_nx = ST_B;
      ST_B:    if (m_axi.bvalid) state_nx = ST_DONE;
      ST_AR:   if (m_axi.arready) state_nx = ST_R;
      // A short burst (early rlast) and an overlong one both end here; r_err flags either.
      ST_R:    if (r_beat && (m_axi.rlast || beat_last)) state_nx = ST_DONE;
      ST_DONE: if (done_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Command payload is only meaningful while the FSM is busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      addr_q <= cmd_addr;
      len_q  <= cmd_len;
      id_q   <= cmd_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q  <= 1'b0;
      resp_acc <= RESP_OKAY;
    end else if (cmd_hs) begin
      write_q  <= cmd_write;
      resp_acc <= cmd_cross ? RESP_SLVERR : RESP_OKAY;
    end else if ((state == ST_B) && m_axi.bvalid) begin
      resp_acc <= m_axi.bresp;
    end else if (r_beat) begin
      resp_acc <= r_err ? RESP_SLVERR : resp_max(resp_acc, m_axi.rresp);
    end
  end

  always_comb begin
    cmd_ready     = (state == ST_IDLE);

    m_axi.awid    = id_q;
    m_axi.awaddr  = addr_q;
    m_axi.awlen   = len_q;
    m_axi.awsize  = AXI_SIZE;
    m_axi.awburst = BURST_INCR;
    m_axi.awlock  = 1'b0;
    m_axi.awcache = CACHE_DEFAULT;
    m_axi.awprot  = PROT_DEFAULT;
    m_axi.awvalid = (state == ST_AW);

    m_axi.wdata   = wr_data;
    m_axi.wstrb   = wr_strb;
    m_axi.wlast   = beat_last;
    m_axi.wvalid  = (state == ST_W) && wr_valid;
    wr_ready      = (state == ST_W) && m_axi.wready;

    m_axi.bready  = (state == ST_B);

    m_axi.arid    = id_q;
    m_axi.araddr  = addr_q;
    m_axi.arlen   = len_q;
    m_axi.arsize  = AXI_SIZE;
    m_axi.arburst = BURST_INCR;
    m_axi.arlock  = 1'b0;
    m_axi.arcache = CACHE_DEFAULT;
    m_axi.arprot  = PROT_DEFAULT;
    m_axi.arvalid = (state == ST_AR);

    m_axi.rready  = (state == ST_R) && rd_ready;
    rd_valid      = (state == ST_R) && m_axi.rvalid;
    rd_data       = m_axi.rdata;
    rd_last       = m_axi.rlast;

    done_valid    = (state == ST_DONE);
    done_write    = write_q;
    done_resp     = resp_acc;
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master against a small AXI4 RAM slave model.
module tb_axi_burst_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [IW-1:0] cmd_id = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          done_valid;
  logic          done_ready = 1'b1;
  logic          done_write;
  logic [1:0]    done_resp;

  axi_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_ready(done_ready), .done_write(done_write),
    .done_resp(done_resp),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [60:0] mk_ax(input logic [31:0] a, input logic [7:0] l, input logic [7:0] id);
    return {a, l, id, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000};
  endfunction

  logic [60:0] exp_aw[$];
  logic [60:0] exp_ar[$];
  logic [32:0] exp_w[$];
  logic [32:0] exp_rd[$];
  logic [2:0]  exp_done[$];

  // Slave model controls
  int          aw_stall = 0;
  int          r_err_beat = -1;
  bit          rid_bad = 1'b0;
  bit          rd_toggle = 1'b0;
  logic [31:0] mem [0:1023];

  initial begin : slave
    logic        s_rst, aw_hs, aw_pend, w_hs, w_l, b_hs, ar_hs, r_hs;
    logic [31:0] w_d, a_a, ar_a, w_addr, r_addr;
    logic [3:0]  w_s;
    logic [7:0]  ar_l, ar_i, r_id;
    int          aw_wait_cnt, r_rem, r_beat;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    aw_wait_cnt = 0; r_rem = 0; r_beat = 0; r_id = '0; w_addr = '0; r_addr = '0;
    bus.awready = 1'b1; bus.wready = 1'b1; bus.arready = 1'b1;
    bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    forever begin
      @(negedge clk);
      s_rst   = rst;
      aw_hs   = bus.awvalid && bus.awready;
      aw_pend = bus.awvalid && !bus.awready;
      a_a     = bus.awaddr;
      w_hs    = bus.wvalid && bus.wready;
      w_d     = bus.wdata; w_s = bus.wstrb; w_l = bus.wlast;
      b_hs    = bus.bvalid && bus.bready;
      ar_hs   = bus.arvalid && bus.arready;
      ar_a    = bus.araddr; ar_l = bus.arlen; ar_i = bus.arid;
      r_hs    = bus.rvalid && bus.rready;
      @(posedge clk); #1;
      if (s_rst) begin
        aw_wait_cnt = 0; r_rem = 0; bus.bvalid = 1'b0;
      end else begin
        if (aw_hs) begin
          w_addr = a_a; aw_wait_cnt = 0;
        end else if (aw_pend) begin
          aw_wait_cnt++;
        end
        if (b_hs) bus.bvalid = 1'b0;
        if (w_hs) begin
          for (int b = 0; b < 4; b++)
            if (w_s[b]) mem[w_addr[11:2]][8*b +: 8] = w_d[8*b +: 8];
          w_addr = w_addr + 32'd4;
          if (w_l) bus.bvalid = 1'b1;
        end
        if (r_hs) begin
          r_beat++; r_rem--;
        end
        if (ar_hs) begin
          r_addr = ar_a; r_rem = int'(ar_l) + 1; r_beat = 0; r_id = ar_i;
        end
      end
      bus.awready = (aw_wait_cnt >= aw_stall);
      bus.rvalid  = (r_rem > 0);
      bus.rdata   = mem[r_addr[11:2] + 10'(r_beat)];
      bus.rlast   = (r_rem == 1);
      bus.rresp   = (r_beat == r_err_beat) ? 2'b11 : 2'b00;
      bus.rid     = rid_bad ? ~r_id : r_id;
    end
  end

  initial begin : rd_ready_drv
    forever begin
      @(posedge clk); #1;
      rd_ready = rd_toggle ? ~rd_ready : 1'b1;
    end
  end

  int          ax_cnt = 0;
  int          done_cyc = 0;
  int          acc_cyc = 0;

  initial begin : monitor
    logic        aw_prev_wait;
    logic [60:0] aw_prev, aw_now, ar_now;
    aw_prev_wait = 1'b0; aw_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_prev_wait = 1'b0;
      end else begin
        aw_now = {bus.awaddr, bus.awlen, bus.awid, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot};
        ar_now = {bus.araddr, bus.arlen, bus.arid, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot};
        if (bus.awvalid || bus.arvalid) ax_cnt++;
        if (aw_prev_wait) check("aw_hold", 64'({bus.awvalid, aw_now}), 64'({1'b1, aw_prev}));
        aw_prev_wait = bus.awvalid && !bus.awready;
        aw_prev = aw_now;
        if (bus.awvalid) check("wr_ready_before_aw", 64'(wr_ready), 64'd0);
        if (bus.awvalid && bus.awready) begin
          if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
          else check("aw_fields", 64'(aw_now), 64'(exp_aw.pop_front()));
        end
        if (bus.arvalid && bus.arready) begin
          if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
          else check("ar_fields", 64'(ar_now), 64'(exp_ar.pop_front()));
        end
        if (bus.wvalid && bus.wready) begin
          if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
          else check("w_beat", 64'({bus.wlast, bus.wdata}), 64'(exp_w.pop_front()));
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
          else check("rd_beat", 64'({rd_last, rd_data}), 64'(exp_rd.pop_front()));
        end
        if (done_valid && done_ready) begin
          done_cyc = cyc;
          if (exp_done.size() == 0) check("done_unexpected", 64'd1, 64'd0);
          else check("done_rec", 64'({done_write, done_resp}), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l, input logic [7:0] id);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) check("cmd_timeout", 64'd0, 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int nb, input logic [31:0] first, input logic [31:0] step);
    int n;
    for (int i = 0; i < nb; i++) begin
      wr_valid = 1'b1; wr_strb = 4'hF; wr_data = first + 32'(i) * step;
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!wr_ready && n < 200);
      if (!wr_ready) check("wr_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_done.size() != 0 && n < 300) begin
      @(negedge clk); #2; n++;
    end
    if (exp_done.size() != 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      exp_done.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [7:0] id,
                          input logic [31:0] first, input logic [31:0] step, input string tag);
    exp_aw.push_back(mk_ax(a, l, id));
    for (int i = 0; i <= int'(l); i++)
      exp_w.push_back({(i == int'(l)), first + 32'(i) * step});
    exp_done.push_back(3'b100);
    issue(1'b1, a, l, id);
    send_beats(int'(l) + 1, first, step);
    wait_done(tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int ax0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({cmd_ready, bus.awvalid, bus.arvalid, bus.wvalid, bus.bready, bus.rready,
                               done_valid, done_resp, wr_ready, rd_valid}), 64'h400);
    rst = 1'b0;

    // 4-beat write, immediate-ready slave; also the minimum command-to-done latency
    do_write(32'h100, 8'd3, 8'h5A, 32'h11, 32'h11, "write4");
    check("write_latency", 64'(done_cyc - acc_cyc), 64'd7);

    // Read back with rd_ready toggling
    rd_toggle = 1'b1;
    exp_ar.push_back(mk_ax(32'h100, 8'd3, 8'h21));
    exp_rd.push_back({1'b0, 32'h11}); exp_rd.push_back({1'b0, 32'h22});
    exp_rd.push_back({1'b0, 32'h33}); exp_rd.push_back({1'b1, 32'h44});
    exp_done.push_back(3'b000);
    issue(1'b0, 32'h100, 8'd3, 8'h21);
    wait_done("read4");
    rd_toggle = 1'b0;

    // 4KB crossing: no bus traffic, SLVERR
    ax0 = ax_cnt;
    exp_done.push_back(3'b110);
    issue(1'b1, 32'hFF8, 8'd3, 8'h01);
    wait_done("cross_wr");
    exp_done.push_back(3'b010);
    issue(1'b0, 32'hFF8, 8'd3, 8'h02);
    wait_done("cross_rd");
    check("cross_no_ax", 64'(ax_cnt - ax0), 64'd0);

    // Burst ending exactly on the page boundary is legal
    do_write(32'hFF0, 8'd3, 8'h03, 32'h0F0F0001, 32'h1, "edge_wr");

    // AW held off for 5 cycles
    aw_stall = 5;
    do_write(32'h300, 8'd1, 8'h44, 32'hA0A0A0A0, 32'h01010101, "aw_stall");
    aw_stall = 0;

    // DECERR on beat 2 of 4
    r_err_beat = 1;
    exp_ar.push_back(mk_ax(32'h100, 8'd3, 8'h31));
    for (int i = 0; i < 4; i++) exp_rd.push_back({(i == 3), 32'(i + 1) * 32'h11});
    exp_done.push_back(3'b011);
    issue(1'b0, 32'h100, 8'd3, 8'h31);
    wait_done("rresp_err");
    r_err_beat = -1;

    // RID mismatch
    rid_bad = 1'b1;
    exp_ar.push_back(mk_ax(32'h100, 8'd3, 8'h32));
    for (int i = 0; i < 4; i++) exp_rd.push_back({(i == 3), 32'(i + 1) * 32'h11});
    exp_done.push_back(3'b010);
    issue(1'b0, 32'h100, 8'd3, 8'h32);
    wait_done("rid_err");
    rid_bad = 1'b0;

    // Reset while W beat 2 of 4 is presented
    exp_aw.push_back(mk_ax(32'h200, 8'd3, 8'h77));
    exp_w.push_back({1'b0, 32'hDEAD0001});
    issue(1'b1, 32'h200, 8'd3, 8'h77);
    send_beats(1, 32'hDEAD0001, 32'h0);
    wr_valid = 1'b1; wr_strb = 4'hF; wr_data = 32'hDEAD0002;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_burst", 64'({cmd_ready, bus.awvalid, bus.arvalid, bus.wvalid, bus.bready, bus.rready,
                                   done_valid, done_resp, wr_ready, rd_valid}), 64'h400);
    rst = 1'b0;
    wr_valid = 1'b0;

    // Zero-length write and read after the reset
    do_write(32'h400, 8'd0, 8'h09, 32'hCAFEF00D, 32'h0, "zero_wr");
    exp_ar.push_back(mk_ax(32'h400, 8'd0, 8'h0A));
    exp_rd.push_back({1'b1, 32'hCAFEF00D});
    exp_done.push_back(3'b000);
    issue(1'b0, 32'h400, 8'd0, 8'h0A);
    wait_done("zero_rd");

    repeat (3) @(posedge clk);
    check("queues_empty", 64'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size() + exp_done.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Single-outstanding AXI4 initiator that converts a simple command/stream interface into AXI4 INCR bursts. It drives the same AXI4 slave port set as our simulated RAM (`s_axi_*` on the slave side) and lets testbench sequencers and proxy logic issue full-width read and write bursts. It also reports per-command completion status.

## Interface
Parameters:
- `DATA_WIDTH`, 32, AXI data width in bits.
- `ADDR_WIDTH`, 32, AXI address width in bits.
- `STRB_WIDTH`, `DATA_WIDTH/8`, strobe width.
- `ID_WIDTH`, 8, AXI ID width.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 selects write, 0 selects read.
- `cmd_addr` in ADDR_WIDTH: start byte address, aligned to STRB_WIDTH.
- `cmd_len` in 8: beats minus 1.
- `cmd_id` in ID_WIDTH: AXI ID.
- `wr_data` in DATA_WIDTH, `wr_strb` in STRB_WIDTH, `wr_valid` in 1, `wr_ready` out 1: write-data stream.
- `rd_data` out DATA_WIDTH, `rd_last` out 1, `rd_valid` out 1, `rd_ready` in 1: read-data stream.
- `done_valid` out 1, `done_ready` in 1, `done_write` out 1, `done_resp` out 2: completion record.
- `m_axi_aw*` (id, addr, len, size, burst, lock, cache, prot, valid out; ready in), `m_axi_w*` (data, strb, last, valid out; ready in), `m_axi_b*` (id, resp, valid in; ready out): AXI4 write channels.
- `m_axi_ar*` and `m_axi_r*`: AXI4 read channels, same widths as the write channels.

## Operation
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE: `cmd_ready=1`.
  - On handshake, latch all command fields, set `beat_cnt=cmd_len`, `resp_acc=0`.
  - Write goes to AW, read goes to AR.
  - If `cmd_addr[11:0] + (cmd_len+1)*STRB_WIDTH > 4096` (4KB cross), no bus traffic is issued: go to DONE with `done_resp=2'b10`.
- AW/AR: `awvalid`/`arvalid` are held with stable fields until ready, then the FSM moves to W/R.
  - len = latched len; size = `$clog2(STRB_WIDTH)`; burst = `2'b01`; lock = 0; cache = `4'b0011`; prot = 0.
- W: combinational pass-through.
  - `m_axi_wvalid = wr_valid`, `wr_ready = m_axi_wready`, `wlast = (beat_cnt==0)`.
  - Each beat decrements `beat_cnt`.
  - The last beat goes to B.
  - `wr_ready=0` in every other state.
- B: `bready=1`. On `bvalid`, `resp_acc=bresp`, go to DONE.
- R: pass-through.
  - `rd_valid = m_axi_rvalid`, `m_axi_rready = rd_ready`, `rd_data = rdata`, `rd_last = rlast`.
  - Per beat: `resp_acc = max(resp_acc, rresp)`.
  - If `rid != latched id`, or `rlast` disagrees with `beat_cnt==0`, set `resp_acc=2'b10`.
  - The FSM leaves R on the beat where `rlast` or `beat_cnt==0` is true, whichever comes first, and goes to DONE.
- DONE: `done_valid=1` with `done_write` and `done_resp`; returns to IDLE on `done_ready`.
- `bid` is ignored.

## Timing
- Reset: state IDLE; `cmd_ready=1`, all AXI valids/readies 0, `done_valid=0`, `done_resp=0`, `wr_ready=0`, `rd_valid=0`.
- Reset mid-burst abandons the transaction immediately; there is no drain.
- `awvalid`/`arvalid` rise on the cycle after command acceptance. Minimum command-to-AW latency is 1 cycle.
- Minimum write command to `done_valid`: 1 (AW) + N+1 (W) + 1 (B) + 1 cycles.
- Valid signals never drop without a handshake. Payload is stable while valid is high without ready.
- `cmd_ready` is 0 from acceptance until the `done` handshake completes, so there is exactly one outstanding command.
- Zero-length burst (`cmd_len=0`): a single beat with `wlast=1`.
- `beat_cnt` is 8-bit and never wraps; underflow is impossible because the FSM exits at 0.

## Structure
- The shared `axi_pkg` holds:
  - burst encodings (`BURST_INCR=2'b01`)
  - response codes (`RESP_OKAY=0`, `RESP_EXOKAY=1`, `RESP_SLVERR=2`, `RESP_DECERR=3`)
  - the state enum
  - the 4KB-crossing function
- Single module with no submodules. Optional: `axi_beat_counter` for shared count/last logic.

## Test plan
- Write `addr=0x100`, `len=3`, data `0x11..0x44`, `strb=0xF`, RAM slave with immediate ready: 1 AW, 4 W beats with `wlast` only on the 4th, then `done_resp=0`, `done_write=1`.
- Read the same address back with `len=3` and `rd_ready` toggling every other cycle: `rd_data` is `0x11,0x22,0x33,0x44`, `rd_last` is set on beat 4, and no beat is lost or duplicated.
- `cmd_addr=0xFF8`, `len=3`, 32-bit bus (crosses 4KB): no AW/AR asserted, `done_resp=2'b10`.
- Slave holds `awready` low for 5 cycles: `awvalid` and the AW fields stay stable throughout, and `wr_ready` stays 0 until the AW handshake.
- Read with slave returning `rresp=2'b11` on beat 2 of 4, or `rid` mismatched: `done_resp` is `2'b11` or `2'b10` respectively.
- Assert `rst` during W beat 2 of 4: the next cycle shows IDLE, `cmd_ready=1`, and all valids 0; a subsequent write completes normally.
